// File: rtl/up_pkg.sv
// ---------------------------------------------------------------------------
// up_pkg: constants and types shared by the up_core peripheral blocks.
//   - BYTE_W   : width of the memory-mapped byte
//   - MAP_ADDR : address of the mapped byte inside up_core
//   - state_e  : 3-bit state encoding of the mailbox arbiter/sequencer
// ---------------------------------------------------------------------------
package up_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned MAP_ADDR = 128;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StIntHi   = 3'd2,
        StIntLo   = 3'd3,
        StWaitAck = 3'd4,
        StDone    = 3'd5
    } state_e;

endpackage

// File: rtl/up_mbox_arb_if.sv
// ---------------------------------------------------------------------------
// up_mbox_arb_if: requester and core-side signals of the mailbox arbiter.
//   Requester side : req, req_data (byte i at [8i+7:8i]), done, resp_data,
//                    resp_tmo, busy
//   Core side      : mem_map_load, mem_map_in, mem_map_out, core_int
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters + core)
// ---------------------------------------------------------------------------
interface up_mbox_arb_if #(
    parameter int unsigned REQS = 4
);
    logic [REQS-1:0]   req;
    logic [8*REQS-1:0] req_data;
    logic [REQS-1:0]   done;
    logic [7:0]        resp_data;
    logic              resp_tmo;
    logic              busy;
    logic              mem_map_load;
    logic [7:0]        mem_map_in;
    logic [7:0]        mem_map_out;
    logic              core_int;

    modport slave (
        input  req, req_data, mem_map_out,
        output done, resp_data, resp_tmo, busy, mem_map_load, mem_map_in, core_int
    );

    modport master (
        output req, req_data, mem_map_out,
        input  done, resp_data, resp_tmo, busy, mem_map_load, mem_map_in, core_int
    );
endinterface

// File: rtl/up_rr_pick.sv
// ---------------------------------------------------------------------------
// up_rr_pick: combinational round-robin picker.
// Ports:
//   i_req   - request vector
//   i_ptr   - highest-priority index (search starts here, wraps upward)
//   o_valid - any request present
//   o_idx   - index of the first set request at or after i_ptr
// ---------------------------------------------------------------------------
module up_rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic                 o_valid,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int unsigned IW = $clog2(N);

    logic [31:0] w_j;

    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        w_j     = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins.
        for (int k = N - 1; k >= 0; k--) begin
            w_j = 32'(i_ptr) + 32'(k);
            if (w_j >= 32'(N)) begin
                w_j = w_j - 32'(N);
            end
            if (i_req[w_j[IW-1:0]]) begin
                o_idx = w_j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/up_mbox_arb.sv
// ---------------------------------------------------------------------------
// up_mbox_arb: mailbox arbiter/sequencer in front of the up_core mapped byte.
// Grants one of REQS requesters round-robin, writes its byte into the mapped
// byte, pulses core_int for INT_HOLD cycles, waits for the ISR to overwrite
// the byte and returns the new value with a one-hot done pulse.
// Ports:
//   clk - clock
//   Rst - asynchronous active-high reset
//   bus - up_mbox_arb_if.slave (requester handshake + core mapped-byte port)
// Optional feature: define UP_MBOX_TIMEOUT_EN to force completion (with
// resp_tmo=1) after TIMEOUT cycles in WAIT_ACK; otherwise WAIT_ACK waits
// indefinitely and resp_tmo is tied low.
// ---------------------------------------------------------------------------
module up_mbox_arb
    import up_pkg::*;
#(
    parameter int unsigned REQS     = 4,
    parameter int unsigned INT_HOLD = 4,
    parameter int unsigned TIMEOUT  = 200
) (
    input  logic         clk,
    input  logic         Rst,
    up_mbox_arb_if.slave bus
);
    localparam int unsigned IW = $clog2(REQS);

    if (REQS < 2 || REQS > 8) begin : g_bad_reqs
        $error("up_mbox_arb: REQS must be 2..8");
    end
    if (INT_HOLD < 1 || INT_HOLD > 255) begin : g_bad_hold
        $error("up_mbox_arb: INT_HOLD must be 1..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_tmo
        $error("up_mbox_arb: TIMEOUT must be 1..255");
    end

    state_e              r_state, w_state_d;
    logic [IW-1:0]       r_gnt, w_gnt_d;
    logic [IW-1:0]       r_ptr, w_ptr_d;
    logic [BYTE_W-1:0]   r_sent, w_sent_d;
    logic [7:0]          r_hold_cnt, w_hold_cnt_d;
    logic [REQS-1:0]     r_done, w_done_d;
    logic [BYTE_W-1:0]   r_resp_data, w_resp_data_d;
    logic                r_load, w_load_d;
    logic [BYTE_W-1:0]   r_map_in, w_map_in_d;
    logic                r_int, w_int_d;
    logic                r_busy, w_busy_d;
    logic                w_pick_valid;
    logic [IW-1:0]       w_pick_idx;
`ifdef UP_MBOX_TIMEOUT_EN
    logic [7:0]          r_tmo_cnt, w_tmo_cnt_d;
    logic                r_resp_tmo, w_resp_tmo_d;
`endif

    up_rr_pick #(
        .N (REQS)
    ) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_d     = r_state;
        w_gnt_d       = r_gnt;
        w_ptr_d       = r_ptr;
        w_sent_d      = r_sent;
        w_hold_cnt_d  = r_hold_cnt;
        w_resp_data_d = r_resp_data;
`ifdef UP_MBOX_TIMEOUT_EN
        w_tmo_cnt_d   = r_tmo_cnt;
        w_resp_tmo_d  = r_resp_tmo;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_gnt_d   = w_pick_idx;
                    w_sent_d  = bus.req_data[BYTE_W*int'(w_pick_idx) +: BYTE_W];
                    w_state_d = StLoad;
                end
            end
            StLoad: begin
                w_hold_cnt_d = 8'(INT_HOLD - 1);
                w_state_d    = StIntHi;
            end
            StIntHi: begin
                if (r_hold_cnt == 8'd0) begin
                    w_state_d = StIntLo;
                end else begin
                    w_hold_cnt_d = r_hold_cnt - 8'd1;
                end
            end
            StIntLo: begin
`ifdef UP_MBOX_TIMEOUT_EN
                w_tmo_cnt_d = 8'd0;
`endif
                w_state_d = StWaitAck;
            end
            StWaitAck: begin
                // The ISR acknowledges by changing the mapped byte.
                if (bus.mem_map_out != r_sent) begin
                    w_resp_data_d = bus.mem_map_out;
`ifdef UP_MBOX_TIMEOUT_EN
                    w_resp_tmo_d  = 1'b0;
`endif
                    w_state_d     = StDone;
                end
`ifdef UP_MBOX_TIMEOUT_EN
                else if (r_tmo_cnt == 8'(TIMEOUT - 1)) begin
                    w_resp_data_d = bus.mem_map_out;
                    w_resp_tmo_d  = 1'b1;
                    w_state_d     = StDone;
                end else begin
                    w_tmo_cnt_d = r_tmo_cnt + 8'd1;
                end
`endif
            end
            StDone: begin
                w_ptr_d   = (r_gnt == IW'(REQS - 1)) ? '0 : r_gnt + 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        w_load_d   = (w_state_d == StLoad);
        w_map_in_d = (w_state_d == StLoad) ? w_sent_d : r_map_in;
        w_int_d    = (w_state_d == StIntHi);
        w_busy_d   = (w_state_d != StIdle);
        w_done_d   = (w_state_d == StDone) ? (REQS'(1) << r_gnt) : '0;
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state     <= StIdle;
            r_gnt       <= '0;
            r_ptr       <= '0;
            r_sent      <= '0;
            r_hold_cnt  <= '0;
            r_done      <= '0;
            r_resp_data <= '0;
            r_load      <= 1'b0;
            r_map_in    <= '0;
            r_int       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_gnt       <= w_gnt_d;
            r_ptr       <= w_ptr_d;
            r_sent      <= w_sent_d;
            r_hold_cnt  <= w_hold_cnt_d;
            r_done      <= w_done_d;
            r_resp_data <= w_resp_data_d;
            r_load      <= w_load_d;
            r_map_in    <= w_map_in_d;
            r_int       <= w_int_d;
            r_busy      <= w_busy_d;
        end
    end

`ifdef UP_MBOX_TIMEOUT_EN
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_tmo_cnt  <= '0;
            r_resp_tmo <= 1'b0;
        end else begin
            r_tmo_cnt  <= w_tmo_cnt_d;
            r_resp_tmo <= w_resp_tmo_d;
        end
    end
    assign bus.resp_tmo = r_resp_tmo;
`else
    assign bus.resp_tmo = 1'b0;
`endif

    assign bus.done         = r_done;
    assign bus.resp_data    = r_resp_data;
    assign bus.busy         = r_busy;
    assign bus.mem_map_load = r_load;
    assign bus.mem_map_in   = r_map_in;
    assign bus.core_int     = r_int;

endmodule
